pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline (IF/ID/EX/MEM/WB).

---
 rtl/pipe_hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
//   Generates the hold/advance and bubble controls for the four inter-stage
//   registers (F2D, D2E, E2M, M2W) and the PC write-enable/select. The inputs
//   are memory busy, mul/div busy, load-use and EX redirect.
//   A redirect that arrives while a fetch is outstanding is parked in WAIT.
//   It completes on the cycle that fetch returns, and that returning
//   (stale) instruction is killed.
// Ports:
//   clk, reset        clock; asynchronous active-low reset
//   imem_busy         fetch outstanding this cycle
//   dmem_busy         MEM-stage access outstanding
//   ex_busy           multi-cycle EX op not finished
//   load_use          ID depends on a load in EX
//   redirect          EX taken branch/jump/mispredict
//   redirect_pc       redirect target
//   reg_en[3:0]       advance enables [0]F2D [1]D2E [2]E2M [3]M2W
//   reg_flush[3:0]    bubble insert, overrides reg_en
//   pc_en, pc_sel     PC write enable; 1 selects pc_target
//   pc_target         redirect target (0 when pc_sel=0)
//   fetch_kill        discard the fetch returning this cycle
//   perf_stall_cyc    cycles with pc_en==0        (PIPE_HAZARD_PERF_EN only)
//   perf_flush_cnt    redirects accepted in RUN   (PIPE_HAZARD_PERF_EN only)
// Build option: define PIPE_HAZARD_PERF_EN to add the performance counters.
module pipe_hazard_ctrl #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            imem_busy,
  input  logic            dmem_busy,
  input  logic            ex_busy,
  input  logic            load_use,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [3:0]      reg_en,
  output logic [3:0]      reg_flush,
  output logic            pc_en,
  output logic            pc_sel,
  output logic [XLEN-1:0] pc_target,
`ifdef PIPE_HAZARD_PERF_EN
  output logic [CNT_W-1:0] perf_stall_cyc,
  output logic [CNT_W-1:0] perf_flush_cnt,
`endif
  output logic            fetch_kill
);

  typedef enum logic {ST_RUN = 1'b0, ST_WAIT = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic            redir_acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_RUN;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  always_comb begin
    reg_en     = 4'hF;
    reg_flush  = 4'h0;
    pc_en      = 1'b1;
    pc_sel     = 1'b0;
    pc_target  = '0;
    fetch_kill = 1'b0;
    state_d    = state_q;
    pend_pc_d  = pend_pc_q;
    redir_acc  = 1'b0;
    if (!reset) begin
      reg_en    = 4'h0;
      reg_flush = 4'hF;
      pc_en     = 1'b0;
    end else begin
      // While waiting, whatever sits in F2D is younger than the redirect.
      if (state_q == ST_WAIT) reg_flush[0] = 1'b1;
      if (dmem_busy) begin
        pc_en        = 1'b0;
        reg_en[2:0]  = 3'b000;
        reg_flush[3] = 1'b1;
      end else if (ex_busy) begin
        pc_en        = 1'b0;
        reg_en[1:0]  = 2'b00;
        reg_flush[2] = 1'b1;
      end else if (state_q == ST_WAIT) begin
        if (imem_busy) begin
          pc_en = 1'b0;
        end else begin
          fetch_kill = 1'b1;
          pc_sel     = 1'b1;
          pc_target  = pend_pc_q;
          state_d    = ST_RUN;
        end
      end else if (redirect) begin
        redir_acc      = 1'b1;
        reg_flush[1:0] = 2'b11;
        if (!imem_busy) begin
          pc_sel    = 1'b1;
          pc_target = redirect_pc;
        end else begin
          // Fetch in flight: PC must not move until it returns.
          pc_en     = 1'b0;
          pend_pc_d = redirect_pc;
          state_d   = ST_WAIT;
        end
      end else if (load_use) begin
        pc_en        = 1'b0;
        reg_en[0]    = 1'b0;
        reg_flush[1] = 1'b1;
      end else if (imem_busy) begin
        pc_en        = 1'b0;
        reg_flush[0] = 1'b1;
      end
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_en)    stall_q <= stall_q + 1'b1;
      if (redir_acc) flush_q <= flush_q + 1'b1;
    end
  end
  assign perf_stall_cyc = stall_q;
  assign perf_flush_cnt = flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed literal checks followed by random
// stimulus. A behavioural model is compared against the DUT every cycle.
module tb_pipe_hazard_ctrl;
  localparam int XLEN  = 64;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic reset, imem_busy, dmem_busy, ex_busy, load_use, redirect;
  logic [XLEN-1:0] redirect_pc;
  logic [3:0] reg_en, reg_flush;
  logic pc_en, pc_sel, fetch_kill;
  logic [XLEN-1:0] pc_target;
`ifdef PIPE_HAZARD_PERF_EN
  logic [CNT_W-1:0] perf_stall_cyc, perf_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .imem_busy(imem_busy), .dmem_busy(dmem_busy),
    .ex_busy(ex_busy), .load_use(load_use), .redirect(redirect),
    .redirect_pc(redirect_pc), .reg_en(reg_en), .reg_flush(reg_flush),
    .pc_en(pc_en), .pc_sel(pc_sel), .pc_target(pc_target),
`ifdef PIPE_HAZARD_PERF_EN
    .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt),
`endif
    .fetch_kill(fetch_kill)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pending-redirect bookkeeping: did an accepted redirect still owe a PC
  // update, and to where.
  bit              m_pending = 0;
  logic [XLEN-1:0] m_pc = '0;
  int unsigned     m_stall = 0, m_flush = 0;

  // Which single situation governs the cycle, highest priority first.
  typedef enum int {C_RST, C_DMEM, C_EX, C_PEND_HOLD, C_PEND_GO,
                    C_REDIR_GO, C_REDIR_PARK, C_LU, C_IMEM, C_IDLE} case_e;

  function automatic case_e classify();
    if (!reset)        return C_RST;
    if (dmem_busy)     return C_DMEM;
    if (ex_busy)       return C_EX;
    if (m_pending)     return imem_busy ? C_PEND_HOLD : C_PEND_GO;
    if (redirect)      return imem_busy ? C_REDIR_PARK : C_REDIR_GO;
    if (load_use)      return C_LU;
    if (imem_busy)     return C_IMEM;
    return C_IDLE;
  endfunction

  always @(negedge clk) begin
    case_e c;
    logic [3:0] e_en, e_fl;
    logic e_pce, e_sel, e_kill;
    logic [XLEN-1:0] e_tgt;
    c = classify();
    e_en = 4'hF; e_fl = 4'h0; e_pce = 1; e_sel = 0; e_kill = 0; e_tgt = '0;
    case (c)
      C_RST:        begin e_en = 4'h0; e_fl = 4'hF; e_pce = 0; end
      C_DMEM:       begin e_en = 4'b1000; e_fl = 4'b1000; e_pce = 0; end
      C_EX:         begin e_en = 4'b1100; e_fl = 4'b0100; e_pce = 0; end
      C_PEND_HOLD:  e_pce = 0;
      C_PEND_GO:    begin e_kill = 1; e_sel = 1; e_tgt = m_pc; end
      C_REDIR_GO:   begin e_fl = 4'b0011; e_sel = 1; e_tgt = redirect_pc; end
      C_REDIR_PARK: begin e_fl = 4'b0011; e_pce = 0; end
      C_LU:         begin e_en = 4'b1110; e_fl = 4'b0010; e_pce = 0; end
      C_IMEM:       begin e_fl = 4'b0001; e_pce = 0; end
      default: ;
    endcase
    if (c != C_RST && m_pending) e_fl[0] = 1'b1;
    chk("reg_en", 64'(reg_en), 64'(e_en));
    chk("reg_flush", 64'(reg_flush), 64'(e_fl));
    chk("pc_en", 64'(pc_en), 64'(e_pce));
    chk("pc_sel", 64'(pc_sel), 64'(e_sel));
    chk("pc_target", pc_target, e_tgt);
    chk("fetch_kill", 64'(fetch_kill), 64'(e_kill));
`ifdef PIPE_HAZARD_PERF_EN
    chk("perf_stall", 64'(perf_stall_cyc), 64'(m_stall));
    chk("perf_flush", 64'(perf_flush_cnt), 64'(m_flush));
`endif
    // advance model to the next edge
    if (c == C_RST) begin
      m_pending = 0; m_pc = '0; m_stall = 0; m_flush = 0;
    end else begin
      if (!e_pce) m_stall++;
      if (c == C_REDIR_GO || c == C_REDIR_PARK) m_flush++;
      if (c == C_REDIR_PARK) begin m_pending = 1; m_pc = redirect_pc; end
      if (c == C_PEND_GO) m_pending = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic rst, input logic im, input logic dm, input logic ex,
                       input logic lu, input logic rd, input logic [XLEN-1:0] pc);
    @(posedge clk); #1;
    reset = rst; imem_busy = im; dmem_busy = dm; ex_busy = ex;
    load_use = lu; redirect = rd; redirect_pc = pc;
    #2;
  endtask

  task automatic idle(); drive(1, 0, 0, 0, 0, 0, '0); endtask

  initial begin
    reset = 0; imem_busy = 0; dmem_busy = 0; ex_busy = 0;
    load_use = 0; redirect = 0; redirect_pc = '0;
    drive(0, 0, 0, 0, 0, 0, '0);
    chk("rst_flush", 64'(reg_flush), 64'hF);
    chk("rst_en", 64'(reg_en), 64'h0);
    chk("rst_pc_en", 64'(pc_en), 64'h0);

    idle();
    chk("idle_en", 64'(reg_en), 64'hF);
    chk("idle_flush", 64'(reg_flush), 64'h0);
    chk("idle_pc_en", 64'(pc_en), 64'h1);

    drive(1, 0, 0, 0, 1, 0, '0);
    chk("lu_en", 64'(reg_en), 64'hE);
    chk("lu_flush", 64'(reg_flush), 64'h2);
    chk("lu_pc_en", 64'(pc_en), 64'h0);
    idle();
    chk("lu_after_en", 64'(reg_en), 64'hF);

    drive(1, 0, 0, 0, 0, 1, 64'h8000_0040);
    chk("rd_sel", 64'(pc_sel), 64'h1);
    chk("rd_tgt", pc_target, 64'h8000_0040);
    chk("rd_flush", 64'(reg_flush), 64'h3);
    idle();
    chk("rd_run_flush", 64'(reg_flush), 64'h0);
    chk("rd_run_sel", 64'(pc_sel), 64'h0);

    drive(1, 1, 0, 0, 0, 1, 64'h8000_0100);
    chk("park_pc_en", 64'(pc_en), 64'h0);
    chk("park_flush", 64'(reg_flush), 64'h3);
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 0, 0, 0, 0, '0);
      chk("wait_pc_en", 64'(pc_en), 64'h0);
      chk("wait_flush", 64'(reg_flush), 64'h1);
    end
    idle();
    chk("wait_kill", 64'(fetch_kill), 64'h1);
    chk("wait_sel", 64'(pc_sel), 64'h1);
    chk("wait_tgt", pc_target, 64'h8000_0100);
    idle();
    chk("wait_done_kill", 64'(fetch_kill), 64'h0);
    chk("wait_done_flush", 64'(reg_flush), 64'h0);

    drive(1, 0, 1, 0, 1, 1, 64'h1234);
    chk("dm_en", 64'(reg_en), 64'h8);
    chk("dm_flush", 64'(reg_flush), 64'h8);
    chk("dm_pc_en", 64'(pc_en), 64'h0);
    drive(1, 0, 0, 0, 1, 1, 64'h1234);
    chk("dm_rd_sel", 64'(pc_sel), 64'h1);
    chk("dm_rd_tgt", pc_target, 64'h1234);
    idle();

    drive(1, 1, 0, 0, 0, 1, 64'hABCD);
    drive(0, 1, 0, 0, 0, 0, '0);
    chk("rst_wait_flush", 64'(reg_flush), 64'hF);
    idle();
    chk("rst_wait_kill", 64'(fetch_kill), 64'h0);
    chk("rst_wait_sel", 64'(pc_sel), 64'h0);

`ifdef PIPE_HAZARD_PERF_EN
    drive(0, 0, 0, 0, 0, 0, '0);
    for (int i = 0; i < 5; i++) drive(1, 1, 0, 0, 0, 0, '0);
    idle();
    chk("perf_5", 64'(perf_stall_cyc), 64'd5);
    drive(0, 0, 0, 0, 0, 0, '0);
    chk("perf_rst_stall", 64'(perf_stall_cyc), 64'd0);
    chk("perf_rst_flush", 64'(perf_flush_cnt), 64'd0);
`endif

    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 199) != 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 4) == 0), {$urandom, $urandom});
    end
    idle();
    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
